// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle add/sub/slt and a WIDTH-cycle shift-and-add multiply.
// Results are registered and announced with a one-cycle done pulse.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int             CW     = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  LAST   = CW'(WIDTH - 1);
  localparam logic [2:0]     OP_ADD = 3'b010;
  localparam logic [2:0]     OP_SUB = 3'b100;
  localparam logic [2:0]     OP_SLT = 3'b110;
  localparam logic [2:0]     OP_MUL = 3'b101;

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] mcand, mplier, acc, acc_next, alu_out;
  logic [CW-1:0]    count;
  logic             accept, accept_mul, mul_last;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    accept     = (state == IDLE) && start;
    accept_mul = accept && (alu_control == OP_MUL);
    mul_last   = (state == MUL) && (count == LAST);
    acc_next   = mplier[0] ? acc + mcand : acc;
    state_next = state;
    if (accept_mul)    state_next = MUL;
    else if (mul_last) state_next = IDLE;

    alu_out = src_a + src_b;
    case (alu_control)
      OP_ADD:  alu_out = src_a + src_b;
      OP_SUB:  alu_out = src_a - src_b;
      OP_SLT:  alu_out = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: alu_out = src_a + src_b;
    endcase
  end

  assign busy = (state == MUL);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done   <= 1'b0;
      result <= '0;
      zero   <= 1'b1;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_mul) begin
            mcand  <= src_a;
            mplier <= src_b;
            acc    <= '0;
            count  <= '0;
          end else if (accept) begin
            result <= alu_out;
            zero   <= (alu_out == '0);
            done   <= 1'b1;
          end
        end
        MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + CW'(1);
          // The final partial product is folded in on the same edge that publishes it.
          if (mul_last) begin
            result <= acc_next;
            zero   <= (acc_next == '0);
            done   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases plus randomized operations
// compared against a plain-arithmetic reference model.
module tb_alu_seq;

  localparam int         WIDTH  = 32;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b101;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [2:0]       alu_control;
  logic [WIDTH-1:0] src_a, src_b;
  logic             busy, done, zero;
  logic [WIDTH-1:0] result;

  int tests = 0;
  int fails = 0;

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .alu_control (alu_control),
    .src_a       (src_a),
    .src_b       (src_b),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .zero        (zero)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] ref_alu(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a, b);
    case (op)
      OP_SUB:  return a - b;
      OP_SLT:  return ($signed(a) < $signed(b)) ? 1 : 0;
      OP_MUL:  return a * b;
      default: return a + b;
    endcase
  endfunction

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; issues one request and follows it to completion.
  // For a multiply, inputs are scrambled every busy cycle and a one-cycle add
  // start is injected at busy cycle 'poke' (negative: none).
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [WIDTH-1:0] a, b, input int poke);
    logic [WIDTH-1:0] exp;
    exp         = ref_alu(op, a, b);
    alu_control = op;
    src_a       = a;
    src_b       = b;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (op == OP_MUL) begin
      for (int i = 0; i < WIDTH; i++) begin
        check({tag, "_busy"}, WIDTH'(busy), 1);
        check({tag, "_nodone"}, WIDTH'(done), 0);
        src_a       = $urandom;
        src_b       = $urandom;
        alu_control = 3'($urandom);
        if (i == poke) begin
          start       = 1'b1;
          alu_control = OP_ADD;
          src_a       = 1;
          src_b       = 1;
        end
        @(negedge clk);
        start = 1'b0;
      end
    end
    check({tag, "_result"}, result, exp);
    check({tag, "_done"}, WIDTH'(done), 1);
    check({tag, "_zero"}, WIDTH'(zero), WIDTH'(exp == 0));
    check({tag, "_idle"}, WIDTH'(busy), 0);
    @(negedge clk);
    check({tag, "_done_drop"}, WIDTH'(done), 0);
    check({tag, "_hold"}, result, exp);
  endtask

  initial begin
    logic [2:0]       op;
    logic [WIDTH-1:0] a, b;

    rst_n       = 1'b0;
    start       = 1'b1;
    alu_control = OP_ADD;
    src_a       = 9;
    src_b       = 9;
    repeat (3) @(negedge clk);
    check("rst_result", result, 0);
    check("rst_zero", WIDTH'(zero), 1);
    check("rst_done", WIDTH'(done), 0);
    check("rst_busy", WIDTH'(busy), 0);

    // First edge with reset released must accept.
    rst_n = 1'b1;
    run_op("add_7_5", OP_ADD, 7, 5, -1);
    run_op("sub_eq", OP_SUB, 5, 5, -1);
    run_op("sub_wrap", OP_SUB, 0, 1, -1);
    run_op("slt_neg", OP_SLT, 32'hFFFF_FFFF, 1, -1);
    run_op("slt_pos", OP_SLT, 1, 32'hFFFF_FFFF, -1);
    run_op("unk_011", 3'b011, 2, 3, -1);
    run_op("add_wrap", OP_ADD, 32'hFFFF_FFFF, 1, -1);
    run_op("mul_a", OP_MUL, 32'h0001_0003, 32'h0000_0010, -1);
    run_op("mul_neg", OP_MUL, 32'hFFFF_FFFF, 3, -1);
    run_op("mul_ign", OP_MUL, 6, 7, 9);
    run_op("mul_late", OP_MUL, 32'h1234_5678, 32'h9ABC_DEF1, WIDTH - 1);

    // Reset in the middle of a multiply aborts it without a done pulse.
    alu_control = OP_MUL;
    src_a       = 6;
    src_b       = 7;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    check("abort_busy_pre", WIDTH'(busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", WIDTH'(busy), 0);
    check("abort_result", result, 0);
    check("abort_zero", WIDTH'(zero), 1);
    check("abort_done", WIDTH'(done), 0);
    rst_n = 1'b1;
    repeat (WIDTH) begin
      @(negedge clk);
      check("abort_no_done", WIDTH'(done), 0);
    end
    run_op("add_3_4", OP_ADD, 3, 4, -1);

    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 4))
        0:       op = OP_ADD;
        1:       op = OP_SUB;
        2:       op = OP_SLT;
        3:       op = OP_MUL;
        default: op = 3'b111;
      endcase
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? a : WIDTH'($urandom);
      run_op("rand", op, a, b, int'($urandom_range(0, 2 * WIDTH)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width; the multiply iteration count equals WIDTH.
REQ-002 clk  input  1  Single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  Reset, synchronous and active-low, sampled on the rising edge of clk.
REQ-004 start  input  1  Request strobe; accepted only when busy=0.
REQ-005 alu_control  input  3  Operation code: 010 add, 100 sub, 110 slt, 101 mult; any other code executes as add.
REQ-006 src_a  input  WIDTH  Operand A, sampled on the accept edge.
REQ-007 src_b  input  WIDTH  Operand B, sampled on the accept edge.
REQ-008 busy  output  1  High while a multiply is in progress.
REQ-009 done  output  1  One-cycle pulse marking a new valid result.
REQ-010 result  output  WIDTH  Registered result; holds its value until the next completion.
REQ-011 zero  output  1  Registered; high when result equals 0.

Function
REQ-012 The block SHALL implement an FSM with states IDLE and MUL, held in registers.
REQ-013 The accept edge SHALL be a rising edge with rst_n=1, state=IDLE and start=1; operands and alu_control SHALL be sampled only on that edge.
REQ-014 For add, sub, slt and unknown codes, the block SHALL write result and zero on the accept edge, assert done for exactly the following cycle, and stay in IDLE (latency 1, busy stays 0).
REQ-015 add/sub SHALL wrap modulo 2^WIDTH with no overflow indication.
REQ-016 slt SHALL compare src_a and src_b as signed two's complement and produce 1 or 0, zero-extended to WIDTH.
REQ-017 For mult, the accept edge SHALL load multiplicand=src_a, multiplier=src_b, accumulator=0 and count=0, and move to MUL; busy SHALL be 1 from the next cycle.
REQ-018 Each MUL edge SHALL add the multiplicand to the accumulator if multiplier[0]=1, shift the multiplicand left 1, shift the multiplier right 1, and increment count.
REQ-019 On the WIDTH-th MUL edge, the block SHALL write the final accumulator value (low WIDTH bits of the unsigned product, equal to the low bits of the signed product) to result, update zero, pulse done, and return to IDLE.
REQ-020 Mult latency SHALL be WIDTH+1 edges from the accept edge to the result write; done SHALL be high for exactly one cycle.
REQ-021 busy SHALL be high exactly in MUL state.
REQ-022 start while busy=1 SHALL be ignored and not queued; the operands and control in use SHALL be unaffected.
REQ-023 start on the same edge as a completion SHALL not be accepted, because state is still MUL; it may be accepted on the next edge.
REQ-024 Changes on src_a, src_b or alu_control during MUL SHALL not affect the result.
REQ-025 done SHALL be 0 on every cycle except the one cycle following a completion.
REQ-026 The count register SHALL be $clog2(WIDTH)+1 bits wide so that it never wraps before termination.

Reset
REQ-027 An edge with rst_n=0 SHALL force state=IDLE, busy=0, done=0, result=0, zero=1, and clear the accumulator, multiplicand, multiplier and count.
REQ-028 Reset SHALL take priority over start and over an in-progress multiply; an aborted multiply SHALL produce no done pulse.
REQ-029 The first accept SHALL be possible on the first edge with rst_n=1.

Verification
REQ-030 add: after reset, start with alu_control=010, A=7, B=5 -> next cycle result=12, done=1, zero=0, busy=0; following cycle done=0.
REQ-031 sub and zero flag: alu_control=100, A=5, B=5 -> result=0, zero=1; then A=0, B=1 -> result=0xFFFFFFFF, zero=0.
REQ-032 slt signed: alu_control=110, A=0xFFFFFFFF, B=1 -> result=1; A=1, B=0xFFFFFFFF -> result=0; unknown code 011 with A=2, B=3 -> result=5.
REQ-033 mult: alu_control=101, A=0x0001_0003, B=0x0000_0010 -> busy high for 32 cycles, done at edge 33 after accept, result=0x0010_0030; A=0xFFFFFFFF (-1), B=3 -> result=0xFFFFFFFD.
REQ-034 Ignored start: during a multiply of 6x7, pulse start with add of 1+1 at cycle 10 -> result=42 with a single done pulse, and the add is not executed afterwards.
REQ-035 Reset mid-multiply: assert rst_n=0 at cycle 15 of a multiply -> next cycle busy=0, result=0, zero=1, no done pulse; a new add 3+4 then yields 7 with latency 1.
